// File: rtl/cipher_bridge_pkg.sv
// Shared definitions for the Wishbone-to-block-cipher bridge:
// register offsets, bit indices, FSM states and the block type.
package cipher_bridge_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DIN    = 8'h10;
    localparam logic [7:0] OFF_DOUT   = 8'h20;
    localparam logic [7:0] OFF_KEY    = 8'h30;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_MODE   = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_TMO  = 3;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] nxt,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_cipher_if.sv
// Wishbone slave bus bundle between the management SoC
// and the cipher bridge.
interface wb_cipher_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_cipher_regs.sv
// Wishbone decode, single-pulse ack, byte-masked register writes
// and read mux for the cipher bridge.
module wb_cipher_regs
    import cipher_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_cipher_if.slave wb,
    input  logic       busy,
    input  logic       done,
    input  logic       err,
    input  logic       timeout,
    input  block_t     dout,
    output block_t     din,
    output block_t     key,
    output logic       irq_en,
    output logic       mode,
    output logic       start,
    output logic       start_mode,
    output logic       err_set,
    output logic [2:0] w1c
);

    logic        hit, ack, wr, wr_ctrl;
    logic [7:0]  off;
    logic [31:0] dat, rdata;
    logic [3:0]  sel;
    logic [6:0]  base;
    logic        word_ok;
    logic        is_ctrl, is_stat, is_din, is_dout, is_key;

    assign off  = wb.wbs_adr_i[7:0];
    assign dat  = wb.wbs_dat_i;
    assign sel  = wb.wbs_sel_i;
    assign base = {off[3:2], 5'b0};

    assign hit = wb.wbs_stb_i & wb.wbs_cyc_i
               & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);

    assign word_ok = (off[1:0] == 2'b00);
    assign is_ctrl = (off == OFF_CTRL);
    assign is_stat = (off == OFF_STATUS);
    assign is_din  = word_ok && (off[7:4] == OFF_DIN[7:4]);
    assign is_dout = word_ok && (off[7:4] == OFF_DOUT[7:4]);
    assign is_key  = word_ok && (off[7:4] == OFF_KEY[7:4]);

    // Ack drops after one cycle even with stb held, so a held
    // request is never acked on consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= hit & ~ack;
    end

    assign wr      = ack & hit & wb.wbs_we_i;
    assign wr_ctrl = wr & is_ctrl & sel[0];

    assign start      = wr_ctrl & dat[CTRL_START] & ~busy;
    assign start_mode = dat[CTRL_MODE];

    assign err_set = busy & (
        (wr_ctrl & (dat[CTRL_START] | (dat[CTRL_MODE] != mode)))
        | (wr & (is_din | is_key)));

    assign w1c = (wr & is_stat & sel[0])
               ? dat[ST_TMO:ST_DONE] : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din    <= '0;
            key    <= '0;
            irq_en <= 1'b0;
            mode   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= dat[CTRL_IRQ_EN];
                if (!busy) mode <= dat[CTRL_MODE];
            end
            if (wr && is_din && !busy)
                din[base +: 32] <= byte_merge(din[base +: 32], dat, sel);
            if (wr && is_key && !busy)
                key[base +: 32] <= byte_merge(key[base +: 32], dat, sel);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            is_ctrl: rdata = {29'd0, mode, irq_en, 1'b0};
            is_stat: rdata = {28'd0, timeout, err, done, busy};
            is_din:  rdata = din[base +: 32];
            is_dout: rdata = dout[base +: 32];
            is_key:  rdata = key[base +: 32];
            default: rdata = '0;
        endcase
    end

    assign wb.wbs_ack_o = ack;
    assign wb.wbs_dat_o = ack ? rdata : '0;

endmodule

// File: rtl/wb_cipher_bridge.sv
// Cipher bridge top: launch FSM, result capture and interrupt.
// Optional WAIT watchdog enabled by defining CIPHER_TIMEOUT_EN.
module wb_cipher_bridge
    import cipher_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    wb_cipher_if.slave wb,
    output logic       blk_valid_o,
    input  logic       blk_ready_i,
    output block_t     blk_data_o,
    output block_t     key_o,
    output logic       mode_o,
    input  logic       res_valid_i,
    input  block_t     res_data_i,
    output logic       irq_o
);

    state_t     state, state_n;
    block_t     din, key, dout;
    logic       irq_en, mode, start, start_mode, err_set;
    logic [2:0] w1c;
    logic       busy, done, err, timeout;
    logic       done_set, tmo_hit, tmo_expire;

    wb_cipher_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .wb         (wb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .timeout    (timeout),
        .dout       (dout),
        .din        (din),
        .key        (key),
        .irq_en     (irq_en),
        .mode       (mode),
        .start      (start),
        .start_mode (start_mode),
        .err_set    (err_set),
        .w1c        (w1c)
    );

    assign busy        = (state != IDLE);
    assign blk_valid_o = (state == SEND);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else             state <= state_n;
    end

    always_comb begin
        state_n  = state;
        done_set = 1'b0;
        tmo_hit  = 1'b0;
        unique case (state)
            IDLE: if (start) state_n = SEND;
            SEND: if (blk_ready_i) state_n = WAIT;
            WAIT: begin
                if (res_valid_i) begin
                    state_n  = IDLE;
                    done_set = 1'b1;
                end else if (tmo_expire) begin
                    state_n = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Hardware set of done/err beats a same-cycle W1C.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            blk_data_o <= '0;
            key_o      <= '0;
            mode_o     <= 1'b0;
            dout       <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (start) begin
                blk_data_o <= din;
                key_o      <= key;
                mode_o     <= start_mode;
            end
            if (done_set) dout <= res_data_i;
            done  <= done_set | (done & ~w1c[0] & ~start);
            err   <= err_set | tmo_hit | (err & ~w1c[1]);
            irq_o <= irq_en & (done | timeout);
        end
    end

`ifdef CIPHER_TIMEOUT_EN
    logic [31:0] wcnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            wcnt    <= (state == WAIT) ? wcnt + 32'd1 : '0;
            timeout <= tmo_hit | (timeout & ~w1c[2]);
        end
    end

    assign tmo_expire = (state == WAIT)
                      && (wcnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^{TIMEOUT_CYCLES, w1c[2]};
    assign timeout    = 1'b0;
    assign tmo_expire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cipher_bridge.sv
// Directed self-checking bench for wb_cipher_bridge with a small
// behavioural cipher core (ready after 3 cycles, result after 10).
`timescale 1ns/1ps
module tb_wb_cipher_bridge;
    import cipher_bridge_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam block_t RESULT =
        128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   blk_valid_o, blk_ready_i, mode_o;
    logic   res_valid_i, irq_o;
    block_t blk_data_o, key_o, res_data_i;

    int   vectors = 0;
    int   miscompares = 0;
    int   hs_count = 0;
    logic core_respond = 1'b1;

    wb_cipher_if bus();

    wb_cipher_bridge #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb          (bus),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_data_o  (blk_data_o),
        .key_o       (key_o),
        .mode_o      (mode_o),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    // Core model: ready on the 3rd cycle of valid, result 10 cycles later.
    initial begin : core_model
        int ph, cnt;
        ph = 0;
        cnt = 0;
        blk_ready_i = 1'b0;
        res_valid_i = 1'b0;
        res_data_i  = '0;
        forever begin
            @(negedge clk);
            res_valid_i = 1'b0;
            if (!rst_n) begin
                ph = 0;
                cnt = 0;
                blk_ready_i = 1'b0;
            end else if (ph == 0) begin
                if (blk_valid_o) begin
                    cnt++;
                    if (cnt == 3) begin
                        blk_ready_i = 1'b1;
                        ph = 1;
                    end
                end
            end else if (ph == 1) begin
                blk_ready_i = 1'b0;
                hs_count++;
                cnt = 0;
                ph = 2;
            end else begin
                cnt++;
                if (cnt == 10 && core_respond) begin
                    res_valid_i = 1'b1;
                    res_data_i  = RESULT;
                    cnt = 0;
                    ph = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] A(input logic [7:0] off);
        return BASE + {24'd0, off};
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic we,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] q);
        logic got;
        got = 1'b0;
        q = '0;
        @(negedge clk);
        bus.wbs_adr_i = a;
        bus.wbs_dat_i = d;
        bus.wbs_sel_i = s;
        bus.wbs_we_i  = we;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                got = 1'b1;
                q = bus.wbs_dat_o;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        chk("ack", got, 1'b1);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] q;
        xfer(A(off), 1'b1, d, s, q);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] q);
        xfer(A(off), 1'b0, '0, 4'hF, q);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] q;
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            rd(OFF_STATUS, q);
            idle = ~q[ST_BUSY];
        end
        chk(tag, idle, 1'b1);
    endtask

    task automatic wait_hs(input int target);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (hs_count >= target);
        end
        chk("handshake", seen, 1'b1);
    endtask

    initial begin : stim
        logic [31:0] q, d1, d2;
        logic        a1, a2;
        int          n, hs0;

        rst_n = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", blk_valid_o, 1'b0);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_ack", bus.wbs_ack_o, 1'b0);
        chk("rst_dat", bus.wbs_dat_o, 32'h0);
        chk("rst_blk", blk_data_o, 128'h0);
        chk("rst_key", key_o, 128'h0);
        chk("rst_mode", mode_o, 1'b0);
        rst_n = 1'b1;

        // Reset while a block is being offered
        wr(OFF_CTRL, 32'h1, 4'hF);
        chk("send_valid", blk_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_send", blk_valid_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(OFF_STATUS, q);
        chk("status_after_rst", q, 32'h0);

        // Byte-masked write
        wr(OFF_DIN, 32'h11223344, 4'hF);
        wr(OFF_DIN, 32'hAABBCCDD, 4'b0101);
        rd(OFF_DIN, q);
        chk("byte_sel", q, 32'h11BB33DD);

        // Full encrypt
        wr(OFF_KEY + 8'h0, 32'h0c0d0e0f, 4'hF);
        wr(OFF_KEY + 8'h4, 32'h08090a0b, 4'hF);
        wr(OFF_KEY + 8'h8, 32'h04050607, 4'hF);
        wr(OFF_KEY + 8'hC, 32'h00010203, 4'hF);
        wr(OFF_DIN + 8'h0, 32'hccddeeff, 4'hF);
        wr(OFF_DIN + 8'h4, 32'h8899aabb, 4'hF);
        wr(OFF_DIN + 8'h8, 32'h44556677, 4'hF);
        wr(OFF_DIN + 8'hC, 32'h00112233, 4'hF);
        wr(OFF_CTRL, 32'h3, 4'hF);
        chk("enc_valid", blk_valid_o, 1'b1);
        chk("enc_blk", blk_data_o,
            128'h00112233445566778899aabbccddeeff);
        chk("enc_key", key_o,
            128'h000102030405060708090a0b0c0d0e0f);
        chk("enc_mode", mode_o, 1'b0);
        wait_idle("enc_idle");
        rd(OFF_STATUS, q);
        chk("enc_status", q, 32'h2);
        rd(OFF_DOUT + 8'h0, q);
        chk("dout0", q, 32'h70b4c55a);
        rd(OFF_DOUT + 8'h4, q);
        chk("dout1", q, 32'hd8cdb780);
        rd(OFF_DOUT + 8'h8, q);
        chk("dout2", q, 32'h6a7b0430);
        rd(OFF_DOUT + 8'hC, q);
        chk("dout3", q, 32'h69c4e0d8);
        chk("enc_irq", irq_o, 1'b1);
        chk("enc_hs", hs_count, 1);
        rd(OFF_CTRL, q);
        chk("ctrl_rb", q, 32'h2);
        wr(OFF_STATUS, 32'h2, 4'hF);
        repeat (2) @(negedge clk);
        chk("irq_clr", irq_o, 1'b0);
        rd(OFF_STATUS, q);
        chk("done_clr", q, 32'h0);

        // Busy collision: DIN write and second start during WAIT
        hs0 = hs_count;
        wr(OFF_CTRL, 32'h3, 4'hF);
        wait_hs(hs0 + 1);
        wr(OFF_DIN + 8'h4, 32'h0000DEAD, 4'hF);
        wr(OFF_CTRL, 32'h3, 4'hF);
        rd(OFF_DOUT + 8'h0, q);
        chk("dout_busy", q, 32'h70b4c55a);
        rd(OFF_STATUS, q);
        chk("busy_err", q, 32'h5);
        wait_idle("col_idle");
        rd(OFF_STATUS, q);
        chk("col_status", q, 32'h6);
        rd(OFF_DIN + 8'h4, q);
        chk("din1_kept", q, 32'h8899aabb);
        repeat (5) @(negedge clk);
        chk("col_novalid", blk_valid_o, 1'b0);
        chk("col_hs", hs_count, hs0 + 1);
        wr(OFF_STATUS, 32'h6, 4'hF);
        rd(OFF_STATUS, q);
        chk("col_clr", q, 32'h0);

        // Decrypt with irq disabled
        wr(OFF_CTRL, 32'h5, 4'hF);
        chk("dec_mode", mode_o, 1'b1);
        wait_idle("dec_idle");
        repeat (3) @(negedge clk);
        chk("dec_noirq", irq_o, 1'b0);
        rd(OFF_CTRL, q);
        chk("dec_ctrl", q, 32'h4);
        wr(OFF_STATUS, 32'h2, 4'hF);

        // Bus edges
        rd(8'h40, q);
        chk("unmapped", q, 32'h0);
        @(negedge clk);
        bus.wbs_adr_i = BASE + 32'h100;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.wbs_ack_o) n++;
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        chk("out_window", n, 0);
        @(negedge clk);
        bus.wbs_adr_i = A(OFF_CTRL);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        @(negedge clk);
        a1 = bus.wbs_ack_o;
        d1 = bus.wbs_dat_o;
        @(negedge clk);
        a2 = bus.wbs_ack_o;
        d2 = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        chk("held_ack1", a1, 1'b1);
        chk("held_dat1", d1, 32'h4);
        chk("held_ack2", a2, 1'b0);
        chk("held_dat2", d2, 32'h0);

`ifdef CIPHER_TIMEOUT_EN
        core_respond = 1'b0;
        hs0 = hs_count;
        wr(OFF_CTRL, 32'h3, 4'hF);
        wait_hs(hs0 + 1);
        n = 0;
        while (!irq_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, 17);
        rd(OFF_STATUS, q);
        chk("tmo_status", q, 32'hC);
        rd(OFF_DOUT + 8'h0, q);
        chk("tmo_dout", q, 32'h70b4c55a);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_cipher_bridge.md
Name: wb_cipher_bridge

Overview:
- Wishbone slave front-end inside the user project; sits between the management-SoC Wishbone port and the 128-bit block cipher core.
- Assembles 32-bit bus writes into 128-bit key/data blocks and launches the core over a valid/ready handshake.
- Captures the 128-bit result into readable registers and raises a maskable interrupt on completion.

Parameters:
- BASE_ADDR, 32'h3000_0000, user-area base; block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8].
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with CIPHER_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- blk_valid_o  out  1  block offered to core.
- blk_ready_i  in  1  core accepts block.
- blk_data_o, key_o  out  128 each  plaintext/ciphertext block, key.
- mode_o  out  1  0 = encrypt, 1 = decrypt.
- res_valid_i  in  1  one-cycle result strobe from core.
- res_data_i  in  128  result block.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync deassert upstream): all outputs 0; all registers 0; FSM IDLE.
- Register map (offset = adr[7:0]):
  - 0x00 CTRL: [0] start (self-clearing, reads 0), [1] irq_en, [2] mode.
  - 0x04 STATUS: [0] busy (RO), [1] done (W1C), [2] err (W1C), [3] timeout (W1C).
  - 0x10–0x1C DIN0..3; 0x20–0x2C DOUT0..3 (RO); 0x30–0x3C KEY0..3. Word 0 = bits [31:0].
- Wishbone:
  - Ack is a one-cycle pulse asserted the cycle after stb&cyc with base match; it deasserts the following cycle even if stb is held, so there is no back-to-back ack on the same request.
  - Write takes effect on the ack cycle; wbs_sel_i masks bytes of CTRL, DIN and KEY.
  - Unmapped offsets inside the window: ack, read 0, write ignored.
  - Outside the window: no ack.
  - wbs_dat_o is 0 whenever ack is low.
- FSM IDLE -> SEND -> WAIT -> IDLE:
  - IDLE: a write to CTRL with start=1 latches DIN/KEY/mode onto blk_data_o/key_o/mode_o, clears done, enters SEND.
  - SEND: blk_valid_o=1; outputs are held stable until blk_valid_o&blk_ready_i, then WAIT.
  - WAIT: on res_valid_i, capture res_data_i into DOUT, set done, go IDLE.
  - res_valid_i outside WAIT is ignored.
- busy = (state != IDLE).
- Start, DIN write, KEY write, or CTRL.mode write while busy: dropped, err set. irq_en writes are always accepted.
- Simultaneous W1C of done and hardware set of done in the same cycle: set wins.
- DOUT is retained until the next result; DOUT reads while busy return the previous result.
- irq_o = irq_en & done, registered (1-cycle lag).
- Reset mid-operation: FSM to IDLE; blk_valid_o drops immediately.

Optional Feature:
- Macro CIPHER_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. At count == TIMEOUT_CYCLES-1 without res_valid_i, the FSM goes IDLE and sets timeout and err; DOUT is unchanged; irq_o = irq_en & (done | timeout).
- Not defined: WAIT waits indefinitely; STATUS[3] reads 0; no counter is present.

Decomposition:
- Package cipher_bridge_pkg: register offset constants, STATUS/CTRL bit indices, FSM state enum (IDLE/SEND/WAIT), 128-bit block typedef.
- One sub-module, wb_cipher_regs: Wishbone decode, ack generation, byte-masked register writes, read mux.
- Top level holds the FSM, handshake, result capture, irq and optional watchdog.

Test Plan:
- Reset mid-SEND: drive wb_rst_n_i low while blk_valid_o=1 -> blk_valid_o=0 immediately; STATUS reads 0 after reset.
- Full encrypt: write KEY=000102..0F, DIN=00112233..EEFF, CTRL=0x3; core raises ready after 3 cycles, returns res_valid with 69C4E0D8..C55A after 10 cycles -> DOUT0..3 match; STATUS=0x2; irq_o=1; W1C of 0x2 clears done and irq_o.
- Byte select: write DIN0=0xAABBCCDD with sel=4'b0101 over 0x11223344 -> reads 0x11BB33DD.
- Busy collision: write start, then DIN1=0xDEAD and a second start during WAIT -> DIN1 unchanged, err=1, exactly one blk_valid_o handshake.
- Bus edges: offset 0x40 read -> ack, data 0; address BASE+0x100 -> no ack for 8 cycles; held stb -> single-cycle ack pulse.
- CIPHER_TIMEOUT_EN with TIMEOUT_CYCLES=16: core never responds -> busy clears 16 cycles after WAIT entry, STATUS=0xC, DOUT unchanged.
